// File: rtl/reg_pipeline_nbit.sv
// DEPTH-stage WIDTH-bit delay pipeline with valid tracking, stall, flush,
// occupancy count and a selectable stage tap.
module reg_pipeline_nbit #(
    parameter int unsigned          WIDTH       = 8,
    parameter int unsigned          DEPTH       = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    localparam int unsigned         TW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned         CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] D,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] Q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VALUE;
            end
            valid_d = '0;
            count_d = '0;
        end else if (en) begin
            data_d[0]  = D;
            valid_d[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            // Modular add/sub: the true result always lies in 0..DEPTH.
            count_d = count_q + CW'(in_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        tap_q     = RESET_VALUE;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_q     = data_q[i];
                tap_valid = valid_q[i];
            end
        end
    end

    assign Q       = data_q[DEPTH-1];
    assign q_valid = valid_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_reg_pipeline_nbit.sv
// Directed bench for reg_pipeline_nbit: a DEPTH=4 instance and a DEPTH=3
// instance with a non-zero reset value share all inputs.
module tb_reg_pipeline_nbit;

    logic       clk = 1'b0;
    logic       reset, en, flush, in_valid;
    logic [7:0] d;
    logic [1:0] tap_sel;

    logic [7:0] q4, tq4, q3, tq3;
    logic       qv4, tv4, qv3, tv3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg_pipeline_nbit #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_d4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .D(d), .tap_sel(tap_sel),
        .Q(q4), .q_valid(qv4), .tap_q(tq4), .tap_valid(tv4), .count(cnt4)
    );

    reg_pipeline_nbit #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .D(d), .tap_sel(tap_sel),
        .Q(q3), .q_valid(qv3), .tap_q(tq3), .tap_valid(tv3), .count(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bub_d  [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    logic       bub_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] bub_c  [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    logic [7:0] bub_q  [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    logic       bub_qv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; en = 1'b1; flush = 1'b0;
        in_valid = 1'b1; d = 8'hFF; tap_sel = 2'd0;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_q", q4, 8'h00);
            chk("rst_qv", qv4, 0);
            chk("rst_cnt", cnt4, 0);
            chk("rst_q3", q3, 8'hA5);
        end
        reset = 1'b0;

        for (int i = 1; i <= 6; i++) begin
            d = 8'(i);
            tick();
            chk("str_cnt", cnt4, (i < 4) ? i : 4);
            chk("str_qv", qv4, (i >= 4) ? 1 : 0);
            if (i >= 4) chk("str_q", q4, i - 3);
        end

        flush = 1'b1; d = 8'd200; in_valid = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_cnt", cnt4, 0);
        chk("fl_qv", qv4, 0);
        chk("fl_q", q4, 8'h00);
        chk("fl_tap0", tq4, 8'h00);
        chk("fl_tv0", tv4, 0);
        chk("fl_q3", q3, 8'hA5);

        for (int i = 1; i <= 4; i++) begin
            d = 8'(i);
            tick();
        end
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t);
            #1;
            chk("tap_q", tq4, 4 - t);
            chk("tap_v", tv4, 1);
        end
        tap_sel = 2'd2;
        #1;
        chk("tap3_q2", tq3, 8'd2);
        chk("tap3_v2", tv3, 1);
        tap_sel = 2'd3;
        #1;
        chk("tap3_oor_q", tq3, 8'hA5);
        chk("tap3_oor_v", tv3, 0);
        chk("cnt3_full", cnt3, 3);
        tap_sel = 2'd0;

        d = 8'd10;
        tick();
        chk("stl_q0", q4, 8'd2);
        en = 1'b0; d = 8'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_q", q4, 8'd2);
            chk("stl_cnt", cnt4, 4);
            chk("stl_tap0", tq4, 8'd10);
        end
        en = 1'b1; in_valid = 1'b0; d = 8'd0;
        tick();
        chk("stl_r1", q4, 8'd3);
        tick();
        chk("stl_r2", q4, 8'd4);
        tick();
        chk("stl_r3", q4, 8'd10);
        chk("stl_r3v", qv4, 1);
        chk("stl_cnt1", cnt4, 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d = (i < 4) ? bub_d[i] : 8'd0;
            in_valid = (i < 4) ? bub_v[i] : 1'b0;
            tick();
            chk("bub_cnt", cnt4, bub_c[i]);
            if (i >= 3) begin
                chk("bub_q", q4, bub_q[i-3]);
                chk("bub_qv", qv4, bub_qv[i-3]);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
